imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot loader that receives a framed instruction image over a byte stream
// and writes it word by word into instruction memory while holding the core in reset.
`ifndef XLEN
`define XLEN 32
`endif

module imem_loader #(
    parameter logic [`XLEN-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int               MAX_WORDS = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    input  logic              start_i,
    output logic              imem_we_o,
    output logic [`XLEN-1:0]  imem_addr_o,
    output logic [`XLEN-1:0]  imem_wdata_o,
    output logic              core_rst_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        WAIT_MAGIC,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t      state;
    state_t      nxt;
    logic        accept;
    logic [15:0] len_q;
    logic [15:0] len_full;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [7:0]  xor_q;
    logic [23:0] word_buf;

    assign accept   = rx_valid_i && rx_ready_o;
    assign len_full = {rx_data_i, len_q[7:0]};

    always_comb begin
        nxt = state;
        case (state)
            WAIT_MAGIC: if (accept && rx_data_i == 8'hA5) nxt = LEN0;
            LEN0:       if (accept) nxt = LEN1;
            LEN1: begin
                if (accept) begin
                    if ({1'b0, len_full} > MAX_LEN) nxt = ERR;
                    else if (len_full == 16'd0)     nxt = CSUM;
                    else                            nxt = DATA;
                end
            end
            DATA: begin
                if (accept && byte_idx == 2'd3 && (word_idx + 16'd1) == len_q)
                    nxt = CSUM;
            end
            CSUM:       if (accept) nxt = (rx_data_i == xor_q) ? DONE : ERR;
            DONE, ERR:  if (start_i) nxt = WAIT_MAGIC;
            default:    nxt = WAIT_MAGIC;
        endcase
    end

    // Status outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= WAIT_MAGIC;
            rx_ready_o   <= 1'b1;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            core_rst_o   <= 1'b1;
            imem_we_o    <= 1'b0;
            imem_addr_o  <= '0;
            imem_wdata_o <= '0;
            len_q        <= '0;
            word_idx     <= '0;
            byte_idx     <= '0;
            xor_q        <= '0;
            word_buf     <= '0;
        end else begin
            state      <= nxt;
            rx_ready_o <= !(nxt == DONE || nxt == ERR);
            done_o     <= (nxt == DONE);
            err_o      <= (nxt == ERR);
            core_rst_o <= (nxt != DONE);
            imem_we_o  <= 1'b0;
            case (state)
                LEN0: if (accept) len_q[7:0] <= rx_data_i;
                LEN1: if (accept) len_q[15:8] <= rx_data_i;
                DATA: begin
                    if (accept) begin
                        xor_q    <= xor_q ^ rx_data_i;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= rx_data_i;
                            2'd1: word_buf[15:8]  <= rx_data_i;
                            2'd2: word_buf[23:16] <= rx_data_i;
                            default: begin
                                imem_we_o    <= 1'b1;
                                imem_wdata_o <= {rx_data_i, word_buf};
                                imem_addr_o  <= BASE_ADDR + `XLEN'({word_idx, 2'b00});
                                word_idx     <= word_idx + 16'd1;
                            end
                        endcase
                    end
                end
                DONE, ERR: begin
                    if (start_i) begin
                        word_idx <= '0;
                        byte_idx <= '0;
                        xor_q    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
